int_controller: RTL

//  Prioritising interrupt controller in front of control_unit's single interrupt input.

---
 rtl/int_controller_if.sv | 29 ++
 rtl/int_controller.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/int_controller_if.sv
// Bus and interrupt handshake bundle between control_unit (master) and
// int_controller (slave). NUM_IRQ must match the controller instance.
interface int_controller_if #(
    parameter int NUM_IRQ = 8
);
    localparam int IDW = $clog2(NUM_IRQ);

    logic [3:0]     io_addr;
    logic           io_read;
    logic           io_write;
    logic [15:0]    io_wdata;
    logic [15:0]    io_rdata;
    logic           int_req;
    logic           int_ack;
    logic           int_done;
    logic [15:0]    int_vector;
    logic [IDW-1:0] int_id;
    logic           int_active;

    modport master (
        output io_addr, io_read, io_write, io_wdata, int_ack, int_done,
        input  io_rdata, int_req, int_vector, int_id, int_active
    );

    modport slave (
        input  io_addr, io_read, io_write, io_wdata, int_ack, int_done,
        output io_rdata, int_req, int_vector, int_id, int_active
    );
endinterface

// File: rtl/int_controller.sv
// Prioritising interrupt controller in front of control_unit.
// Rising edges on irq[] latch into PEND; the lowest-index enabled pending
// source is presented as int_req/int_id/int_vector until the CPU acks it,
// then held in service until int_done. MASK at CTRL_ADDR, PEND (W1C) at
// CTRL_ADDR+1.
// Optional feature: define INT_RR_EN for rotating priority (search restarts
// after the last acknowledged source).
module int_controller #(
    parameter int          NUM_IRQ    = 8,
    parameter logic [3:0]  CTRL_ADDR  = 4'hE,
    parameter logic [15:0] VEC_BASE   = 16'h0010,
    parameter logic [15:0] VEC_STRIDE = 16'h0008
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq,
    int_controller_if.slave    bus
);
    localparam int         IDW       = $clog2(NUM_IRQ);
    localparam logic [3:0] PEND_ADDR = CTRL_ADDR + 4'd1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SERVICE
    } state_t;

    state_t             state;
    logic [NUM_IRQ-1:0] sync1, sync2, sync3, edge_q;
    logic [NUM_IRQ-1:0] mask, pend, cand, ack_clr, w1c;
    logic               req_q, active_q;
    logic [IDW-1:0]     id_q;
    logic [15:0]        vec_q;
    logic [15:0]        rdata_q;
    logic               sel_found;
    logic [IDW-1:0]     sel_id;
    logic [IDW-1:0]     scan_idx;
    logic [15:0]        sel_vec;
`ifdef INT_RR_EN
    logic [IDW-1:0]     rr_ptr;
`endif

    // Two-flop synchroniser plus a registered edge pulse per line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= '0;
            sync2  <= '0;
            sync3  <= '0;
            edge_q <= '0;
        end else begin
            sync1  <= irq;
            sync2  <= sync1;
            sync3  <= sync2;
            edge_q <= sync2 & ~sync3;
        end
    end

    assign cand    = pend & mask;
    assign ack_clr = (state == REQ && bus.int_ack) ? (NUM_IRQ'(1) << id_q) : '0;
    assign w1c     = (bus.io_write && bus.io_addr == PEND_ADDR) ? bus.io_wdata[NUM_IRQ-1:0] : '0;

    // Priority search over enabled pending sources, starting at the rotation point
    always_comb begin
        sel_found = 1'b0;
        sel_id    = '0;
        scan_idx  = '0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
`ifdef INT_RR_EN
            scan_idx = IDW'((32'(rr_ptr) + i) % NUM_IRQ);
`else
            scan_idx = IDW'(i);
`endif
            if (!sel_found && cand[scan_idx]) begin
                sel_found = 1'b1;
                sel_id    = scan_idx;
            end
        end
    end

    assign sel_vec = VEC_BASE + 16'(32'(sel_id) * 32'(VEC_STRIDE));

    // Pending/mask registers; a new edge wins over any clear in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
            mask <= '0;
        end else begin
            pend <= (pend & ~(ack_clr | w1c)) | edge_q;
            if (bus.io_write && bus.io_addr == CTRL_ADDR)
                mask <= bus.io_wdata[NUM_IRQ-1:0];
        end
    end

    // Registered IO read port; returns the value held before any same-cycle write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (bus.io_read && bus.io_addr == CTRL_ADDR) begin
            rdata_q <= 16'(mask);
        end else if (bus.io_read && bus.io_addr == PEND_ADDR) begin
            rdata_q <= 16'(pend);
        end else begin
            rdata_q <= '0;
        end
    end

    // Request/service handshake with the CPU; id and vector frozen outside IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            req_q    <= 1'b0;
            active_q <= 1'b0;
            id_q     <= '0;
            vec_q    <= '0;
`ifdef INT_RR_EN
            rr_ptr   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        id_q  <= sel_id;
                        vec_q <= sel_vec;
                        req_q <= 1'b1;
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (bus.int_ack) begin
                        req_q    <= 1'b0;
                        active_q <= 1'b1;
                        state    <= SERVICE;
`ifdef INT_RR_EN
                        rr_ptr   <= (32'(id_q) == NUM_IRQ - 1) ? '0 : id_q + 1'b1;
`endif
                    end
                end
                SERVICE: begin
                    if (bus.int_done) begin
                        active_q <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.int_req    = req_q;
    assign bus.int_active = active_q;
    assign bus.int_id     = id_q;
    assign bus.int_vector = vec_q;
    assign bus.io_rdata   = rdata_q;
endmodule
